// File: rtl/rca_seq_ctrl.sv
// Sequential W-bit adder: a single 4-bit ripple-carry slice is reused once per
// nibble, LSB first, behind a valid/ready request and a held valid/ready result.

module rca4_slice (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       ci,
    output logic [3:0] s,
    output logic       co
);
    logic [4:0] c;

    assign c[0] = ci;

    for (genvar i = 0; i < 4; i++) begin : g_fa
        assign s[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign co = c[4];
endmodule

module rca_seq_ctrl #(
    parameter int NIBBLES = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [4*NIBBLES-1:0] a,
    input  logic [4*NIBBLES-1:0] b,
    input  logic                 cin,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [4*NIBBLES-1:0] sum,
    output logic                 cout,
    output logic                 ovf,
    output logic                 busy
);
    localparam int W  = 4 * NIBBLES;
    localparam int CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

    state_t          state, state_nxt;
    logic [W-1:0]    a_q, b_q, sum_q;
    logic            carry_q, cout_q, ovf_q;
    logic [CW-1:0]   cnt;
    logic [CW+1:0]   base;
    logic            accept, last;
    logic [3:0]      sl_a, sl_b, sl_s;
    logic            sl_co;

    // Bit offset of the nibble currently being added.
    assign base = {cnt, 2'b00};
    assign last = (cnt == CW'(NIBBLES - 1));
    assign sl_a = a_q[base +: 4];
    assign sl_b = b_q[base +: 4];

    rca4_slice u_slice (
        .a  (sl_a),
        .b  (sl_b),
        .ci (carry_q),
        .s  (sl_s),
        .co (sl_co)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accept    = 1'b1;
                    state_nxt = ADD;
                end
            end
            ADD: begin
                busy = 1'b1;
                if (last) state_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cnt     <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else if (accept) begin
            a_q     <= a;
            b_q     <= b;
            carry_q <= cin;
            cnt     <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else if (busy) begin
            sum_q[base +: 4] <= sl_s;
            carry_q          <= sl_co;
            if (last) begin
                cnt    <= '0;
                cout_q <= sl_co;
                // Overflow: like-signed operands whose result sign differs.
                ovf_q  <= (a_q[W-1] == b_q[W-1]) && (sl_s[3] != a_q[W-1]);
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;
endmodule

// File: tb/tb_rca_seq_ctrl.sv
// Directed bench for rca_seq_ctrl (NIBBLES=4): latency, arithmetic corners,
// backpressure, ignored requests while busy and reset abort.

module tb_rca_seq_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, cin, out_valid, out_ready, cout, ovf, busy;
    logic [15:0] a, b, sum;
    int          n_chk = 0;
    int          n_err = 0;

    rca_seq_ctrl #(.NIBBLES(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .ovf(ovf), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Wait for out_valid; returns cycles elapsed since the accepting edge.
    task automatic wait_valid(output int n);
        n = 1;
        while (!out_valid && n < 20) begin
            tick();
            n++;
        end
    endtask

    task automatic run_op(input string tag, input logic [15:0] xa, input logic [15:0] xb,
                          input logic xc, input logic [15:0] es, input logic ec, input logic eo);
        int n;
        chk({tag, ".in_ready"}, in_ready, 1);
        a = xa; b = xb; cin = xc; in_valid = 1'b1;
        tick();
        in_valid = 1'b0; a = '0; b = '0; cin = 1'b0;
        chk({tag, ".busy"}, busy, 1);
        chk({tag, ".sum_cleared"}, sum, 16'h0000);
        wait_valid(n);
        chk({tag, ".latency"}, n, 5);
        chk({tag, ".sum"}, sum, es);
        chk({tag, ".cout"}, cout, ec);
        chk({tag, ".ovf"}, ovf, eo);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({tag, ".back_idle"}, {out_valid, in_ready}, 2'b01);
    endtask

    initial begin
        int n;
        logic stable;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; cin = 1'b0;
        #12;
        chk("rst.outs", {in_ready, out_valid, busy, cout, ovf}, 5'b10000);
        chk("rst.sum", sum, 16'h0000);
        @(posedge clk); #1; rst = 1'b0;

        run_op("add_1_2",   16'h0001, 16'h0002, 1'b0, 16'h0003, 1'b0, 1'b0);
        run_op("ffff_1",    16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
        run_op("7fff_1",    16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
        run_op("0fff_cin",  16'h0FFF, 16'h0000, 1'b1, 16'h1000, 1'b0, 1'b0);
        run_op("8000_8000", 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1);
        run_op("ffff_cin",  16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0);
        run_op("a5a5_5a5b", 16'hA5A5, 16'h5A5B, 1'b0, 16'h0000, 1'b1, 1'b0);

        // Backpressure: result held for 10 cycles with out_ready low.
        a = 16'h1111; b = 16'h2222; cin = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        wait_valid(n);
        chk("bp.latency", n, 5);
        stable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            out_ready = (i == 3) ? 1'b0 : 1'b0;
            if (!(out_valid && !in_ready && sum == 16'h3333 && !cout && !ovf)) stable = 1'b0;
            tick();
        end
        chk("bp.stable", stable, 1);
        chk("bp.still_valid", {out_valid, in_ready}, 2'b10);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("bp.idle", {out_valid, in_ready}, 2'b01);

        // Requests during ADD/DONE are ignored; second set taken only from IDLE.
        a = 16'h0100; b = 16'h0200; in_valid = 1'b1;
        tick();
        a = 16'h0F0F; b = 16'h0101;
        chk("ign.in_ready_add", in_ready, 0);
        wait_valid(n);
        chk("ign.latency", n, 5);
        chk("ign.in_ready_done", in_ready, 0);
        chk("ign.sum_first", sum, 16'h0300);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("ign.idle_ready", in_ready, 1);
        tick();
        in_valid = 1'b0;
        chk("ign.second_busy", busy, 1);
        wait_valid(n);
        chk("ign.second_sum", sum, 16'h1010);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // Reset during ADD aborts with no result ever presented.
        a = 16'h9999; b = 16'h9999; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        rst = 1'b1;
        #1;
        chk("abort.outs", {in_ready, out_valid, busy, cout, ovf}, 5'b10000);
        chk("abort.sum", sum, 16'h0000);
        tick();
        rst = 1'b0;
        stable = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (out_valid || busy) stable = 1'b0;
            tick();
        end
        chk("abort.no_valid", stable, 1);
        run_op("post_rst", 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
